// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences run/split/stop, drives counter enable/clear and display digit selection.
// Optional STOP-state display blinking is compiled in with `define STOPWATCH_BLINK_EN.
module stopwatch_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_ed,
    input  logic        stop_ed,
    input  logic        split_ed,
    input  logic [31:0] live_digits,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [31:0] disp_digits,
    output logic [1:0]  state,
    output logic [3:0]  lap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_SPLIT   = 2'b10,
        S_STOP    = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_stage;
    logic [31:0] r_snap;
    logic        r_split_pend;

    logic        w_coherent;
    logic        w_stop;
    logic        w_split;
    logic        w_start;
    logic        w_pend;
    logic        w_blank;

    // live_digits crosses from the counter domain; only trust it when two consecutive samples agree
    assign w_coherent = (live_digits == r_stage);

    assign w_stop  = stop_ed;
    assign w_split = split_ed & ~stop_ed;
    assign w_start = start_ed & ~stop_ed & ~split_ed;
    assign w_pend  = r_split_pend | w_split;

    assign state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_stage      <= '0;
            r_snap       <= '0;
            r_split_pend <= 1'b0;
            cnt_en       <= 1'b0;
            cnt_clr      <= 1'b1;
            lap_cnt      <= '0;
        end else begin
            r_stage <= live_digits;
            case (r_state)
                S_IDLE: begin
                    lap_cnt      <= '0;
                    r_split_pend <= 1'b0;
                    if (w_start) begin
                        r_state <= S_RUNNING;
                        cnt_en  <= 1'b1;
                        cnt_clr <= 1'b0;
                    end
                end
                S_RUNNING: begin
                    if (w_stop) begin
                        r_state      <= S_STOP;
                        cnt_en       <= 1'b0;
                        r_split_pend <= 1'b0;
                    end else if (w_pend && w_coherent) begin
                        r_snap       <= live_digits;
                        r_state      <= S_SPLIT;
                        r_split_pend <= 1'b0;
                        if (lap_cnt != 4'd9) begin
                            lap_cnt <= lap_cnt + 4'd1;
                        end
                    end else begin
                        r_split_pend <= w_pend;
                    end
                end
                S_SPLIT: begin
                    if (w_stop) begin
                        r_state <= S_STOP;
                        cnt_en  <= 1'b0;
                    end else if (w_split) begin
                        r_state <= S_RUNNING;
                    end
                end
                S_STOP: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        cnt_clr <= 1'b1;
                        lap_cnt <= '0;
                    end else if (w_start) begin
                        r_state <= S_RUNNING;
                        cnt_en  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STOPWATCH_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    // Outside STOP, and on the edge that leaves it, the blink timer is parked so every STOP entry starts visible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_state != S_STOP || w_stop || w_start) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = r_blink_phase & (r_state == S_STOP);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        disp_digits = live_digits;
        if (r_state == S_SPLIT) begin
            disp_digits = r_snap;
        end
        if (w_blank) begin
            disp_digits = '1;
        end
    end

endmodule
